inst_queue: RTL

//  Instruction queue directly downstream of Icache. Buffers fetched 512-bit lines (with fetch PC),

---
 rtl/kiwi_pkg.sv | 23 ++
 rtl/iq_line_fifo.sv | 48 ++++
 rtl/inst_queue.sv | 92 +++++++++
 3 files changed

// File: rtl/kiwi_pkg.sv
// Shared front-end constants and the buffered-line record used by the instruction queue.
package kiwi_pkg;
  localparam int XLEN           = 64;
  localparam int LINE_SIZE      = 512;
  localparam int INST_WIDTH     = 32;
  localparam int WORDS_PER_LINE = 16;
  localparam int OFFSET_WIDTH   = 6;
  localparam int WIDX_W         = $clog2(WORDS_PER_LINE);
  localparam int LPC_W          = XLEN - OFFSET_WIDTH;

  // One fetched line: data, line-aligned PC and the first word fetch asked for.
  typedef struct packed {
    logic [LINE_SIZE-1:0] data;
    logic [LPC_W-1:0]     line_pc;
    logic [WIDX_W-1:0]    start_idx;
  } iq_line_t;

  // Rebuild a byte PC from the line PC and a word index inside the line.
  function automatic logic [XLEN-1:0] word_pc(input logic [LPC_W-1:0] lpc,
                                              input logic [WIDX_W-1:0] w);
    return {lpc, w, 2'b00};
  endfunction
endpackage

// File: rtl/iq_line_fifo.sv
// Circular line buffer for the instruction queue: head/tail/count with push, pop and flush.
module iq_line_fifo
  import kiwi_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  iq_line_t      wr_line,
  output iq_line_t      head_line,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  iq_line_t         mem [DEPTH];
  logic [PW-1:0]    head, tail;

  // Pointer and occupancy state; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Line storage; validity is tracked by count, so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_line;
  end

  assign head_line = mem[head];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
endmodule

// File: rtl/inst_queue.sv
// Instruction queue between Icache and decode: buffers lines, slices them into
// in-order instruction pairs from the fetch offset, back-pressures fetch, flushes on squash.
module inst_queue
  import kiwi_pkg::*;
#(
  parameter int LINE_DEPTH = 4,
  parameter int DEC_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            icache_valid_i,
  input  logic [XLEN-1:0]                 icache_pc_i,
  input  logic [LINE_SIZE-1:0]            icache_data_i,
  output logic                            stall_icache_o,
  output logic [DEC_WIDTH-1:0]            dec_valid_o,
  output logic [DEC_WIDTH*INST_WIDTH-1:0] dec_inst_o,
  output logic [DEC_WIDTH*XLEN-1:0]       dec_pc_o,
  input  logic                            dec_ready_i,
  input  logic                            squash_pipe_i
);
  localparam int CW = $clog2(LINE_DEPTH) + 1;

  iq_line_t                        wr_line, head_line;
  logic [CW-1:0]                   count;
  logic                            full, empty;
  logic                            enq, deq, pop;
  logic [WIDX_W-1:0]               w_q, w_eff;
  logic                            fresh_q;
  logic [WIDX_W:0]                 n_deq, adv;
  logic [DEC_WIDTH-1:0][WIDX_W:0]  slot_idx;

  assign wr_line = '{data:      icache_data_i,
                     line_pc:   icache_pc_i[XLEN-1:OFFSET_WIDTH],
                     start_idx: icache_pc_i[OFFSET_WIDTH-1:2]};

  // Stall depends only on registered occupancy, so a pop never frees a slot the same cycle.
  assign stall_icache_o = full;
  assign enq = icache_valid_i && !full && !squash_pipe_i;
  assign deq = dec_ready_i && dec_valid_o[0];
  assign pop = deq && adv[WIDX_W] && !squash_pipe_i;

  iq_line_fifo #(.DEPTH(LINE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enq),
    .pop       (pop),
    .flush     (squash_pipe_i),
    .wr_line   (wr_line),
    .head_line (head_line),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // A line that just became head reads its own start index instead of the stale word pointer.
  assign w_eff = fresh_q ? head_line.start_idx : w_q;

  // Slot s takes word w+s of the head line; slots stop at the line end and never spill over.
  for (genvar s = 0; s < DEC_WIDTH; s++) begin : g_slot
    assign slot_idx[s]    = {1'b0, w_eff} + (WIDX_W+1)'(s);
    assign dec_valid_o[s] = !empty && !slot_idx[s][WIDX_W];
    assign dec_inst_o[s*INST_WIDTH +: INST_WIDTH] = dec_valid_o[s] ?
      head_line.data[slot_idx[s][WIDX_W-1:0]*INST_WIDTH +: INST_WIDTH] : '0;
    assign dec_pc_o[s*XLEN +: XLEN] = dec_valid_o[s] ?
      word_pc(head_line.line_pc, slot_idx[s][WIDX_W-1:0]) : '0;
  end

  // Words consumed this cycle and where the pointer lands; reaching 16 retires the line.
  always_comb begin
    n_deq = '0;
    for (int s = 0; s < DEC_WIDTH; s++) n_deq = n_deq + (WIDX_W+1)'(dec_valid_o[s]);
    adv = {1'b0, w_eff} + n_deq;
  end

  // Word pointer within the head line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      fresh_q <= 1'b1;
    end else if (squash_pipe_i) begin
      w_q     <= '0;
      fresh_q <= 1'b1;
    end else if (deq) begin
      if (adv[WIDX_W]) begin
        fresh_q <= 1'b1;
      end else begin
        w_q     <= adv[WIDX_W-1:0];
        fresh_q <= 1'b0;
      end
    end
  end
endmodule
